// File: rtl/vga_mode_monitor.sv
// rtl/vga_mode_monitor.sv - VGA timing checker: lock detection, sticky errors, per-frame pixel signature.
// Define VGA_MONITOR_CRC_EN for a CRC-32 signature instead of the additive checksum.
module vga_mode_monitor #(
  parameter int FW = 13,
  parameter int LW = 11
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_vga_hsync,
  input  logic          i_vga_vsync,
  input  logic [7:0]    i_vga_red,
  input  logic [7:0]    i_vga_grn,
  input  logic [7:0]    i_vga_blu,
  input  logic [FW-1:0] i_hm_width,
  input  logic [FW-1:0] i_hm_porch,
  input  logic [FW-1:0] i_hm_synch,
  input  logic [FW-1:0] i_hm_raw,
  input  logic [LW-1:0] i_vm_height,
  input  logic [LW-1:0] i_vm_porch,
  input  logic [LW-1:0] i_vm_synch,
  input  logic [LW-1:0] i_vm_raw,
  output logic          o_locked,
  output logic [4:0]    o_err,
  output logic [31:0]   o_frame_sum,
  output logic          o_frame_stb
);

  typedef enum logic [1:0] {S_SEARCH, S_MEASURE, S_LOCKED} state_t;

  localparam logic [FW-1:0] H_ONE = 1;
  localparam logic [LW-1:0] V_ONE = 1;

`ifdef VGA_MONITOR_CRC_EN
  localparam logic [31:0] SIG_INIT = 32'hFFFF_FFFF;

  function automatic logic [31:0] f_sig(input logic [31:0] acc, input logic [23:0] pix);
    logic [31:0] c;
    c = acc;
    for (int i = 23; i >= 0; i--)
      c = {c[30:0], 1'b0} ^ ((c[31] ^ pix[i]) ? 32'h04C1_1DB7 : 32'h0);
    return c;
  endfunction
`else
  localparam logic [31:0] SIG_INIT = 32'h0;

  function automatic logic [31:0] f_sig(input logic [31:0] acc, input logic [23:0] pix);
    return acc + {8'h0, pix};
  endfunction
`endif

  state_t        r_state, w_state_nxt;
  logic          r_match, w_match_nxt;
  logic [4:0]    r_err, w_err_nxt;
  logic          r_prev_hs, r_prev_vs;
  logic [FW-1:0] r_hpos, w_hpos;
  logic [LW-1:0] r_vpos, w_vpos;
  logic          r_vs_pend;
  logic [FW-1:0] r_hcnt, r_hsw;
  logic [LW-1:0] r_vcnt, r_vsw;
  logic [31:0]   r_acc, r_sum, w_acc_base;
  logic          r_stb;

  logic          w_hs_fall, w_hs_rise, w_vs_fall, w_vs_rise;
  logic          w_line_start, w_active, w_los;
  logic [4:0]    w_fail;
  logic [FW-1:0] w_hsw_exp;
  logic [LW-1:0] w_vsw_exp;
  logic [23:0]   w_pix;

  assign w_hs_fall = r_prev_hs & ~i_vga_hsync;
  assign w_hs_rise = ~r_prev_hs & i_vga_hsync;
  assign w_vs_fall = r_prev_vs & ~i_vga_vsync;
  assign w_vs_rise = ~r_prev_vs & i_vga_vsync;
  assign w_pix     = {i_vga_red, i_vga_grn, i_vga_blu};
  assign w_hsw_exp = i_hm_synch - i_hm_porch;
  assign w_vsw_exp = i_vm_synch - i_vm_porch;

  // Current-cycle position, so the pixel sampled now is judged against it
  always_comb begin
    w_hpos = '0;
    if (w_hs_fall)
      w_hpos = i_hm_porch;
    else if (r_hpos != i_hm_raw - H_ONE)
      w_hpos = r_hpos + H_ONE;
    w_line_start = (w_hpos == '0);
    w_vpos = r_vpos;
    if (w_line_start) begin
      if (w_vs_fall || r_vs_pend)
        w_vpos = i_vm_porch;
      else if (r_vpos == i_vm_raw - V_ONE)
        w_vpos = '0;
      else
        w_vpos = r_vpos + V_ONE;
    end
  end

  assign w_active = (w_hpos < i_hm_width) && (w_vpos < i_vm_height);
  assign w_los    = ~w_hs_fall && ({1'b0, r_hcnt} == {i_hm_raw, 1'b0});

  assign w_fail[0] = w_hs_fall && (r_hcnt != i_hm_raw);
  assign w_fail[1] = w_hs_rise && (r_hsw != w_hsw_exp);
  assign w_fail[2] = w_vs_fall && (r_vcnt != i_vm_raw);
  assign w_fail[3] = w_vs_rise && (r_vsw != w_vsw_exp);
  assign w_fail[4] = (|w_pix) && ((w_hpos >= i_hm_width) || (w_vpos >= i_vm_height));

  always_comb begin
    w_state_nxt = r_state;
    w_match_nxt = r_match;
    w_err_nxt   = r_err;
    case (r_state)
      S_SEARCH: begin
        w_match_nxt = 1'b0;
        if (w_vs_fall) begin
          w_state_nxt = S_MEASURE;
          w_match_nxt = 1'b1;
        end
      end
      S_MEASURE: begin
        if (|w_fail)
          w_match_nxt = 1'b0;
        if (w_vs_fall) begin
          if (r_match && ~|w_fail)
            w_state_nxt = S_LOCKED;
          else
            w_match_nxt = 1'b1;
        end
      end
      S_LOCKED: begin
        if (|w_fail) begin
          w_err_nxt   = r_err | w_fail;
          w_state_nxt = S_MEASURE;
          w_match_nxt = 1'b0;
        end
      end
      default: w_state_nxt = S_SEARCH;
    endcase
    if (w_los) begin
      w_state_nxt = S_SEARCH;
      w_match_nxt = 1'b0;
      if (r_state == S_LOCKED)
        w_err_nxt[4] = 1'b1;
    end
  end

  assign w_acc_base = w_vs_fall ? SIG_INIT : r_acc;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= S_SEARCH;
      r_match   <= 1'b0;
      r_err     <= '0;
      r_prev_hs <= 1'b1;
      r_prev_vs <= 1'b1;
      r_hpos    <= '0;
      r_vpos    <= '0;
      r_vs_pend <= 1'b0;
      r_hcnt    <= '0;
      r_hsw     <= '0;
      r_vcnt    <= '0;
      r_vsw     <= '0;
      r_acc     <= SIG_INIT;
      r_sum     <= '0;
      r_stb     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_match   <= w_match_nxt;
      r_err     <= w_err_nxt;
      r_prev_hs <= i_vga_hsync;
      r_prev_vs <= i_vga_vsync;
      r_hpos    <= w_hpos;
      r_vpos    <= w_vpos;
      r_vs_pend <= w_line_start ? 1'b0 : (r_vs_pend | w_vs_fall);

      // Counters saturate so a dead input cannot wrap into a false match
      if (w_hs_fall)
        r_hcnt <= H_ONE;
      else if (r_hcnt != '1)
        r_hcnt <= r_hcnt + H_ONE;

      if (w_hs_fall)
        r_hsw <= H_ONE;
      else if (~i_vga_hsync && r_hsw != '1)
        r_hsw <= r_hsw + H_ONE;

      if (w_vs_fall)
        r_vcnt <= w_hs_fall ? V_ONE : '0;
      else if (w_hs_fall && r_vcnt != '1)
        r_vcnt <= r_vcnt + V_ONE;

      if (w_vs_fall)
        r_vsw <= w_hs_fall ? V_ONE : '0;
      else if (~i_vga_vsync && w_hs_fall && r_vsw != '1)
        r_vsw <= r_vsw + V_ONE;

      r_acc <= w_active ? f_sig(w_acc_base, w_pix) : w_acc_base;
      r_stb <= 1'b0;
      if (w_vs_fall && r_state == S_LOCKED) begin
        r_sum <= r_acc;
        r_stb <= 1'b1;
      end
    end
  end

  assign o_locked    = (r_state == S_LOCKED);
  assign o_err       = r_err;
  assign o_frame_sum = r_sum;
  assign o_frame_stb = r_stb;

endmodule

// File: tb/tb_vga_mode_monitor.sv
// tb/tb_vga_mode_monitor.sv - Directed/randomized bench for vga_mode_monitor on a reduced video mode.
module tb_vga_mode_monitor;

  localparam int HW = 16, HP = 20, HS = 24, HR = 32;
  localparam int VH = 10, VP = 12, VS = 14, VR = 16;

`ifdef VGA_MONITOR_CRC_EN
  localparam logic [31:0] SIG_INIT = 32'hFFFF_FFFF;
  function automatic logic [31:0] sig_add(input logic [31:0] acc, input logic [23:0] px);
    logic [31:0] c;
    c = acc;
    for (int i = 23; i >= 0; i--)
      c = (c << 1) ^ ((c[31] ^ px[i]) ? 32'h04C1_1DB7 : 32'h0);
    return c;
  endfunction
`else
  localparam logic [31:0] SIG_INIT = 32'h0;
  function automatic logic [31:0] sig_add(input logic [31:0] acc, input logic [23:0] px);
    return acc + 32'(px);
  endfunction
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hs = 1'b1, vs = 1'b1;
  logic [7:0]  r = 8'h0, g = 8'h0, b = 8'h0;
  logic        locked, stb;
  logic [4:0]  err;
  logic [31:0] sum;

  int total = 0, bad = 0;
  int gx = 0, gy = 0;
  int bad_x = -1, bad_y = -1, short_y = -1;
  int stb_cnt = 0, s0;
  int cyc = 0, last_stb = 0, prev_stb = 0;
  logic prev_stb_lvl = 1'b0;
  logic [31:0] model_acc = SIG_INIT, exp_sum = 32'h0;

  always #5 clk = ~clk;

  vga_mode_monitor #(.FW(13), .LW(11)) dut (
    .i_clk(clk), .i_reset(rst),
    .i_vga_hsync(hs), .i_vga_vsync(vs),
    .i_vga_red(r), .i_vga_grn(g), .i_vga_blu(b),
    .i_hm_width(13'(HW)), .i_hm_porch(13'(HP)), .i_hm_synch(13'(HS)), .i_hm_raw(13'(HR)),
    .i_vm_height(11'(VH)), .i_vm_porch(11'(VP)), .i_vm_synch(11'(VS)), .i_vm_raw(11'(VR)),
    .o_locked(locked), .o_err(err), .o_frame_sum(sum), .o_frame_stb(stb)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic h, input logic v, input logic [23:0] px);
    hs = h; vs = v; {r, g, b} = px;
    @(posedge clk); #1;
    cyc++;
    if (stb) begin
      stb_cnt++;
      check("stb_width", {31'b0, prev_stb_lvl}, 32'd0);
      check("frame_sum", sum, exp_sum);
      prev_stb = last_stb;
      last_stb = cyc;
    end
    prev_stb_lvl = stb;
  endtask

  // Ideal generator; the model sums what it emits over the active area per frame
  task automatic gen_cycle();
    logic h, v, act;
    logic [23:0] px;
    h   = !(gx >= HP && gx < HS);
    v   = !(gy >= VP && gy < VS);
    if (gy == short_y && gx == HS - 1) h = 1'b1;
    act = (gx < HW) && (gy < VH);
    px  = act ? 24'($urandom) : 24'h0;
    if (gx == bad_x && gy == bad_y) px = 24'hFF_FFFF;
    if (gx == 0 && gy == VP) begin
      exp_sum   = model_acc;
      model_acc = SIG_INIT;
    end
    if (act) model_acc = sig_add(model_acc, px);
    step(h, v, px);
    gx++;
    if (gx == HR) begin
      gx = 0;
      gy = (gy == VR - 1) ? 0 : gy + 1;
    end
  endtask

  task automatic run_to(input int x, input int y);
    int n = 0;
    while (!(gx == x && gy == y) && n < 2 * HR * VR) begin
      gen_cycle();
      n++;
    end
  endtask

  task automatic relock(input string tag);
    run_to(0, VP); gen_cycle();
    check({tag, "_arm"}, {31'b0, locked}, 32'd0);
    run_to(0, VP); gen_cycle();
    check({tag, "_lock"}, {31'b0, locked}, 32'd1);
  endtask

  initial begin
    repeat (3) step(1'b1, 1'b1, 24'h0);
    check("rst_locked", {31'b0, locked}, 32'd0);
    check("rst_err", {27'b0, err}, 32'd0);
    check("rst_sum", sum, 32'd0);
    check("rst_stb", {31'b0, stb}, 32'd0);
    rst = 1'b0;

    // initial acquisition: lock on the second vsync fall
    run_to(0, VP); gen_cycle();
    check("acq_first_fall", {31'b0, locked}, 32'd0);
    run_to(0, VP);
    check("acq_before_2nd", {31'b0, locked}, 32'd0);
    gen_cycle();
    check("acq_2nd_fall", {31'b0, locked}, 32'd1);

    s0 = stb_cnt;
    repeat (3) begin run_to(0, VP); gen_cycle(); end
    check("stb_count", 32'(stb_cnt - s0), 32'd3);
    check("stb_period", 32'(last_stb - prev_stb), 32'(HR * VR));
    check("clean_err", {27'b0, err}, 32'd0);
    check("clean_locked", {31'b0, locked}, 32'd1);

    // one line one cycle long, extra cycle in the front porch
    run_to(HW + 1, 3);
    step(1'b1, 1'b1, 24'h0);
    run_to(HP, 3);
    check("long_pre_locked", {31'b0, locked}, 32'd1);
    gen_cycle();
    check("long_err", {27'b0, err}, 32'h01);
    check("long_unlocked", {31'b0, locked}, 32'd0);
    s0 = stb_cnt;
    relock("long_relock");
    check("long_err_sticky", {27'b0, err}, 32'h01);
    check("long_no_stb", 32'(stb_cnt - s0), 32'd0);

    // hsync pulse one cycle short
    run_to(0, 5);
    check("hsw_pre_locked", {31'b0, locked}, 32'd1);
    short_y = 5;
    run_to(0, 6);
    short_y = -1;
    check("hsw_err", {27'b0, err}, 32'h03);
    check("hsw_unlocked", {31'b0, locked}, 32'd0);
    relock("hsw_relock");

    // loss of signal: hsync held high past two line periods
    run_to(0, 4);
    check("los_pre_locked", {31'b0, locked}, 32'd1);
    repeat (2 * HR + 1) step(1'b1, 1'b1, 24'h0);
    check("los_unlocked", {31'b0, locked}, 32'd0);
    check("los_err", {27'b0, err}, 32'h13);
    relock("los_relock");

    // reset mid-frame while locked
    run_to(5, 3);
    check("mid_rst_pre_locked", {31'b0, locked}, 32'd1);
    rst = 1'b1;
    gen_cycle();
    rst = 1'b0;
    check("mid_rst_locked", {31'b0, locked}, 32'd0);
    check("mid_rst_err", {27'b0, err}, 32'd0);
    check("mid_rst_sum", sum, 32'd0);
    check("mid_rst_stb", {31'b0, stb}, 32'd0);

    // stray pixel before lock: no error, lock delayed by a frame
    run_to(0, VP); gen_cycle();
    check("pre_arm", {31'b0, locked}, 32'd0);
    bad_x = $urandom_range(0, HW - 1);
    bad_y = VH + 1;
    run_to(0, VP); gen_cycle();
    bad_x = -1; bad_y = -1;
    check("pre_pix_nolock", {31'b0, locked}, 32'd0);
    check("pre_pix_err", {27'b0, err}, 32'd0);
    run_to(0, VP); gen_cycle();
    check("pre_pix_lock", {31'b0, locked}, 32'd1);

    // stray pixel in horizontal blanking while locked
    run_to(0, 2);
    check("pix_pre_locked", {31'b0, locked}, 32'd1);
    bad_x = HW + $urandom_range(0, HR - HW - 1);
    bad_y = 2;
    run_to(0, 3);
    bad_x = -1; bad_y = -1;
    check("pix_err", {27'b0, err}, 32'h10);
    check("pix_unlocked", {31'b0, locked}, 32'd0);
    relock("pix_relock");
    s0 = stb_cnt;
    repeat (2) begin run_to(0, VP); gen_cycle(); end
    check("final_stb_count", 32'(stb_cnt - s0), 32'd2);
    check("final_err", {27'b0, err}, 32'h10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
